// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by hazard_ctrl_unit.
package hazard_pkg;

   localparam int CNT_W_DFLT = 16;

   // Zero control bundle on the ID mux src1 input (a bubble).
   localparam logic [7:0] CTRL_BUBBLE = 8'h00;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-high clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: step on inc unless already at the ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall, taken-branch flush and dmem freeze control
// for the 5-stage core, with saturating stall/flush counters.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = CNT_W_DFLT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_branch_taken_i,
   input  logic             dmem_busy_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_write_o,
   output logic             ctrl_sel_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [1:0] BUB_INIT =
      (LU_BUBBLES > 1) ? 2'(LU_BUBBLES - 2) : 2'd0;

   state_e     state_q;
   state_e     state_d;
   logic [1:0] bub_q;
   logic [1:0] bub_d;
   logic       lu;
   logic       rs1_hit;
   logic       rs2_hit;
   logic       stall_inc;
   logic       flush_inc;

   assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   assign lu = id_valid_i && ex_memread_i && (ex_rd_i != 5'd0)
             && (rs1_hit || rs2_hit);

   // Prioritised Mealy outputs and next state: rst, busy, stall, branch, lu.
   always_comb begin
      state_d      = state_q;
      bub_d        = bub_q;
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      idex_write_o = 1'b1;
      ifid_flush_o = 1'b0;
      ctrl_sel_o   = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (rst_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_write_o = 1'b0;
         ifid_flush_o = 1'b1;
         ctrl_sel_o   = 1'b1;
         state_d      = RUN;
         bub_d        = 2'd0;
      end else if (dmem_busy_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_write_o = 1'b0;
      end else if (state_q == LU_STALL) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         ctrl_sel_o   = 1'b1;
         stall_inc    = 1'b1;
         if (bub_q == 2'd0) begin
            state_d = RUN;
         end else begin
            bub_d = bub_q - 2'd1;
         end
      end else if (ex_branch_taken_i) begin
         ifid_flush_o = 1'b1;
         ctrl_sel_o   = 1'b1;
         flush_inc    = 1'b1;
      end else if (lu) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         ctrl_sel_o   = 1'b1;
         stall_inc    = 1'b1;
         if (LU_BUBBLES > 1) begin
            state_d = LU_STALL;
            bub_d   = BUB_INIT;
         end
      end
   end

   // State and remaining-bubble registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         bub_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: three hazard_ctrl_unit configurations driven in
// parallel and compared each cycle against a bubble-debt reference model.
module tb_hazard_ctrl_unit;

   typedef struct packed {
      logic       rst;
      logic       val;
      logic       u1;
      logic       u2;
      logic       mr;
      logic       br;
      logic       busy;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       val = 1'b0;
   logic       u1 = 1'b0;
   logic       u2 = 1'b0;
   logic       mr = 1'b0;
   logic       br = 1'b0;
   logic       busy = 1'b0;
   logic [4:0] rs1 = 5'd0;
   logic [4:0] rs2 = 5'd0;
   logic [4:0] rd = 5'd0;

   logic [4:0]  o0, o1, o2;
   logic [15:0] s0, f0;
   logic [3:0]  s1, f1, s2, f2;
   logic [4:0]  obs [3];
   logic [15:0] scnt [3];
   logic [15:0] fcnt [3];

   int vec = 0;
   int miss = 0;

   int lb [3] = '{1, 2, 3};
   int cmax [3] = '{65535, 15, 15};
   int m_rem [3] = '{0, 0, 0};
   int m_sc [3] = '{0, 0, 0};
   int m_fc [3] = '{0, 0, 0};

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.LU_BUBBLES(1), .CNT_W(16)) dut0 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(val),
      .id_rs1_i(rs1), .id_rs2_i(rs2),
      .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_memread_i(mr), .ex_rd_i(rd),
      .ex_branch_taken_i(br), .dmem_busy_i(busy),
      .pc_write_o(o0[4]), .ifid_write_o(o0[3]),
      .ifid_flush_o(o0[2]), .idex_write_o(o0[1]),
      .ctrl_sel_o(o0[0]),
      .stall_cnt_o(s0), .flush_cnt_o(f0)
   );

   hazard_ctrl_unit #(.LU_BUBBLES(2), .CNT_W(4)) dut1 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(val),
      .id_rs1_i(rs1), .id_rs2_i(rs2),
      .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_memread_i(mr), .ex_rd_i(rd),
      .ex_branch_taken_i(br), .dmem_busy_i(busy),
      .pc_write_o(o1[4]), .ifid_write_o(o1[3]),
      .ifid_flush_o(o1[2]), .idex_write_o(o1[1]),
      .ctrl_sel_o(o1[0]),
      .stall_cnt_o(s1), .flush_cnt_o(f1)
   );

   hazard_ctrl_unit #(.LU_BUBBLES(3), .CNT_W(4)) dut2 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(val),
      .id_rs1_i(rs1), .id_rs2_i(rs2),
      .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_memread_i(mr), .ex_rd_i(rd),
      .ex_branch_taken_i(br), .dmem_busy_i(busy),
      .pc_write_o(o2[4]), .ifid_write_o(o2[3]),
      .ifid_flush_o(o2[2]), .idex_write_o(o2[1]),
      .ctrl_sel_o(o2[0]),
      .stall_cnt_o(s2), .flush_cnt_o(f2)
   );

   assign obs[0] = o0;
   assign obs[1] = o1;
   assign obs[2] = o2;
   assign scnt[0] = s0;
   assign scnt[1] = {12'd0, s1};
   assign scnt[2] = {12'd0, s2};
   assign fcnt[0] = f0;
   assign fcnt[1] = {12'd0, f1};
   assign fcnt[2] = {12'd0, f2};

   // Reference: a load-use hazard opens a debt of LU_BUBBLES bubbles.
   function automatic bit m_lu();
      return val && mr && (rd != 5'd0)
         && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   // Expected {pc_write, ifid_write, ifid_flush, idex_write, ctrl_sel}.
   function automatic logic [4:0] m_out(int i);
      if (rst) return 5'b00101;
      if (busy) return 5'b00000;
      if (m_rem[i] > 0) return 5'b00011;
      if (br) return 5'b11111;
      if (m_lu()) return 5'b00011;
      return 5'b11010;
   endfunction

   function automatic int sat(int v, int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   function automatic void m_tick();
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_rem[i] = 0;
            m_sc[i] = 0;
            m_fc[i] = 0;
         end else if (busy) begin
         end else if (m_rem[i] > 0) begin
            m_rem[i] = m_rem[i] - 1;
            m_sc[i] = sat(m_sc[i], cmax[i]);
         end else if (br) begin
            m_fc[i] = sat(m_fc[i], cmax[i]);
         end else if (m_lu()) begin
            m_rem[i] = lb[i] - 1;
            m_sc[i] = sat(m_sc[i], cmax[i]);
         end
      end
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t lu_s(logic [4:0] r);
      stim_t s;
      s = '0;
      s.val = 1'b1;
      s.u1 = 1'b1;
      s.mr = 1'b1;
      s.rs1 = r;
      s.rd = r;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rst = s.rst;
      val = s.val;
      u1 = s.u1;
      u2 = s.u2;
      mr = s.mr;
      br = s.br;
      busy = s.busy;
      rs1 = s.rs1;
      rs2 = s.rs2;
      rd = s.rd;
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      m_tick();
      #1;
   endtask

   task automatic test_reset();
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(s);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i)) begin
               miss++;
               $display("FAIL reset_ctl dut%0d cyc%0d: got %b want %b",
                        i, c, obs[i], m_out(i));
            end
         end
         advance();
      end
      for (int c = 0; c < 2; c++) begin
         drive(idle());
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || scnt[i] !== 16'(m_sc[i])
                || fcnt[i] !== 16'(m_fc[i])) begin
               miss++;
               $display("FAIL release dut%0d: ctl %b sc %0d fc %0d, want %b %0d %0d",
                        i, obs[i], scnt[i], fcnt[i], m_out(i), m_sc[i], m_fc[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_load_use();
      stim_t q[$];
      stim_t b;
      b = idle();
      b.busy = 1'b1;
      q.push_back(lu_s(5'd5));
      repeat (4) q.push_back(idle());
      q.push_back(lu_s(5'd5));
      repeat (3) q.push_back(b);
      repeat (4) q.push_back(idle());
      foreach (q[k]) begin
         drive(q[k]);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || scnt[i] !== 16'(m_sc[i])
                || fcnt[i] !== 16'(m_fc[i])) begin
               miss++;
               $display("FAIL load_use dut%0d step%0d: ctl %b sc %0d, want %b %0d",
                        i, k, obs[i], scnt[i], m_out(i), m_sc[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_branch_vs_lu();
      stim_t q[$];
      stim_t s;
      s = lu_s(5'd7);
      s.br = 1'b1;
      q.push_back(s);
      q.push_back(idle());
      q.push_back(idle());
      foreach (q[k]) begin
         drive(q[k]);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || scnt[i] !== 16'(m_sc[i])
                || fcnt[i] !== 16'(m_fc[i])) begin
               miss++;
               $display("FAIL branch_lu dut%0d step%0d: ctl %b sc %0d fc %0d, want %b %0d %0d",
                        i, k, obs[i], scnt[i], fcnt[i], m_out(i), m_sc[i], m_fc[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_no_stall();
      stim_t q[$];
      stim_t s;
      s = lu_s(5'd0);
      q.push_back(s);
      s = lu_s(5'd9);
      s.val = 1'b0;
      q.push_back(s);
      s = lu_s(5'd9);
      s.u1 = 1'b0;
      q.push_back(s);
      s.u2 = 1'b1;
      s.rs2 = 5'd9;
      s.rs1 = 5'd3;
      q.push_back(s);
      repeat (3) q.push_back(idle());
      foreach (q[k]) begin
         drive(q[k]);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || scnt[i] !== 16'(m_sc[i])) begin
               miss++;
               $display("FAIL no_stall dut%0d step%0d: ctl %b sc %0d, want %b %0d",
                        i, k, obs[i], scnt[i], m_out(i), m_sc[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      stim_t q[$];
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      q.push_back(s);
      s = idle();
      s.br = 1'b1;
      repeat (20) q.push_back(s);
      foreach (q[k]) begin
         drive(q[k]);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || fcnt[i] !== 16'(m_fc[i])) begin
               miss++;
               $display("FAIL saturate dut%0d step%0d: ctl %b fc %0d, want %b %0d",
                        i, k, obs[i], fcnt[i], m_out(i), m_fc[i]);
            end
         end
         advance();
      end
      drive(idle());
      vec++;
      if (f1 !== 4'd15 || f2 !== 4'd15 || f0 !== 16'd20) begin
         miss++;
         $display("FAIL saturate_final: fc %0d/%0d/%0d want 20/15/15",
                  f0, f1, f2);
      end
      advance();
   endtask

   task automatic test_reset_mid_stall();
      stim_t q[$];
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      q.push_back(lu_s(5'd4));
      q.push_back(s);
      repeat (3) q.push_back(idle());
      foreach (q[k]) begin
         drive(q[k]);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || scnt[i] !== 16'(m_sc[i])
                || fcnt[i] !== 16'(m_fc[i])) begin
               miss++;
               $display("FAIL rst_mid_stall dut%0d step%0d: ctl %b sc %0d fc %0d, want %b %0d %0d",
                        i, k, obs[i], scnt[i], fcnt[i], m_out(i), m_sc[i], m_fc[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int k = 0; k < 400; k++) begin
         s = '0;
         s.rst = ($urandom_range(0, 49) == 0);
         s.val = ($urandom_range(0, 7) != 0);
         s.u1 = $urandom_range(0, 1);
         s.u2 = $urandom_range(0, 1);
         s.mr = $urandom_range(0, 1);
         s.br = ($urandom_range(0, 5) == 0);
         s.busy = ($urandom_range(0, 4) == 0);
         s.rs1 = 5'($urandom_range(0, 3));
         s.rs2 = 5'($urandom_range(0, 3));
         s.rd = 5'($urandom_range(0, 3));
         drive(s);
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (obs[i] !== m_out(i) || scnt[i] !== 16'(m_sc[i])
                || fcnt[i] !== 16'(m_fc[i])) begin
               miss++;
               $display("FAIL random dut%0d cyc%0d: ctl %b sc %0d fc %0d, want %b %0d %0d",
                        i, k, obs[i], scnt[i], fcnt[i], m_out(i), m_sc[i], m_fc[i]);
            end
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_vs_lu();
      test_no_stall();
      test_saturation();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage RISC-V core, sitting directly upstream of the ID-stage control-bundle mux. It drives that mux's select: 0 passes the decoder's 8-bit control bundle, 1 selects the all-zero bundle, i.e. inserts a bubble. It also drives the PC, IF/ID and ID/EX write enables and the IF/ID flush. It sequences multi-cycle load-use stalls, handles taken-branch flushes and data-memory freezes, and keeps saturating stall and flush event counters.

## Interface
- LU_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..3 (2 when MEM→EX forwarding is absent).
- CNT_W, 16: width of the performance counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i, id_rs2_i  in  5 each  ID source register indices.
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  ID instruction reads rs1 / rs2.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rd_i  in  5  EX destination register.
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
- dmem_busy_i  in  1  data memory not ready; freeze the pipeline.
- pc_write_o  out  1  PC register enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  IF/ID clear to NOP.
- idex_write_o  out  1  ID/EX register enable.
- ctrl_sel_o  out  1  control-mux select; 1 = zero bundle (bubble).
- stall_cnt_o  out  CNT_W  load-use bubble cycles, saturating.
- flush_cnt_o  out  CNT_W  taken-branch flush events, saturating.

## Operation
- FSM states: RUN, LU_STALL. A bubble counter bub_q of 2 bits holds the remaining extra bubbles.
- Load-use hazard `lu` is asserted when all of these hold: id_valid_i, ex_memread_i, and ex_rd_i≠0; and at least one of (id_uses_rs1_i and id_rs1_i==ex_rd_i) or (id_uses_rs2_i and id_rs2_i==ex_rd_i).
- Outputs are Mealy (combinational from state and inputs). Priority, highest first: rst_i, dmem_busy_i, branch, stall, normal.
- rst_i=1:
  - outputs pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, ctrl_sel=1.
  - next state RUN, bub_q=0, both counters cleared.
- dmem_busy_i=1, in any state:
  - outputs pc_write=ifid_write=idex_write=0, ifid_flush=0, ctrl_sel=0.
  - state, bub_q and both counters hold.
- RUN with ex_branch_taken_i=1:
  - outputs pc_write=1, ifid_write=1, ifid_flush=1, ctrl_sel=1, idex_write=1.
  - flush_cnt increments. A simultaneous `lu` is ignored because ID is on the wrong path.
- RUN with `lu`:
  - outputs pc_write=0, ifid_write=0, ctrl_sel=1, idex_write=1, ifid_flush=0. stall_cnt increments.
  - If LU_BUBBLES>1: next state LU_STALL with bub_q=LU_BUBBLES-2. Otherwise remain in RUN.
- LU_STALL:
  - outputs as in RUN with `lu`, but the inputs are not re-evaluated. stall_cnt increments.
  - If bub_q==0, next state RUN; otherwise bub_q decrements.
  - ex_branch_taken_i is ignored, because EX holds a bubble.
- RUN, otherwise: pc_write=ifid_write=idex_write=1, ifid_flush=0, ctrl_sel=0.
- Counters saturate at 2^CNT_W−1; they never wrap.

## Timing
- Hazard and flush responses have zero latency (same-cycle combinational). State and counters update at the next rising edge.
- A load-use hazard produces exactly LU_BUBBLES consecutive non-busy cycles with ctrl_sel_o=1 and pc_write_o=0.
- dmem_busy_i cycles stretch a stall without consuming bubbles.
- Reset asserted mid-stall: RUN on the next edge. Release takes effect on the first cycle rst_i=0.
- Counter outputs are registered and reflect events through the previous cycle.

## Structure
- Package hazard_pkg holds:
  - the state enum (RUN, LU_STALL);
  - the bubble-bundle constant CTRL_BUBBLE = 8'h00, tied to the mux's src1 input;
  - the CNT_W default.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice, once per counter.
- Target size: roughly 150–250 lines of RTL in total.

## Test plan
- Reset held 3 cycles, then released with no hazards:
  - during reset, ctrl_sel=1, ifid_flush=1, all enables 0;
  - after release, enables 1, ctrl_sel=0, counters 0.
- LU_BUBBLES=1, ex_memread=1, ex_rd=5, id_rs1=5, uses_rs1=1:
  - exactly 1 cycle with pc_write=0, ctrl_sel=1;
  - stall_cnt=1.
- LU_BUBBLES=2, same hazard, with dmem_busy=1 for 3 cycles after the first bubble:
  - 2 bubble cycles separated by 3 frozen cycles;
  - stall_cnt=2.
- ex_branch_taken=1 and `lu` both active in the same cycle:
  - ifid_flush=1, ctrl_sel=1, pc_write=1;
  - flush_cnt=1, stall_cnt unchanged.
- ex_rd=0 with ex_memread=1 and id_rs1=0: no stall. Also id_valid=0 with a matching register: no stall.
- CNT_W=4 with 20 flushes: flush_cnt sticks at 15. Reset asserted in LU_STALL: RUN and counters 0 on the next edge.
